// File: rtl/context_swap_controller.sv
// Context swap sequencer between the kernel register bank (shift 0) and the
// process bank (shift 1). It also runs the preemption quantum timer.
//
//    state     | meaning
//    ----------+-----------------------------------------------------------
//    ST_KERNEL | kernel bank selected, timer stopped, waits for rfe
//    ST_USER   | process bank selected, timer running, waits for a request
//    ST_SAVE   | reg 28 <= saved user PC (pc_operation = 01)
//    ST_ENTER  | reg 28 <= interrupt code, fetch jumps to the kernel vector
//    ST_EXIT   | fetch jumps to the resume PC, timer reloaded from quantum
module context_swap_controller #(
   parameter int unsigned             DATA_WIDTH    = 32,
   parameter int unsigned             INTRPT_WIDTH  = 6,
   parameter int unsigned             QUANTUM_WIDTH = 16,
   parameter logic [INTRPT_WIDTH-1:0] TIMER_CODE    = INTRPT_WIDTH'(1),
   parameter logic [DATA_WIDTH-1:0]   KERNEL_VECTOR = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     hlt,
   input  logic [INTRPT_WIDTH-1:0]  ext_intrpt,
   input  logic                     rfe,
   input  logic [DATA_WIDTH-1:0]    rfe_target,
   input  logic [DATA_WIDTH-1:0]    pc_in,
   input  logic                     quantum_we,
   input  logic [QUANTUM_WIDTH-1:0] quantum_data,
   output logic                     read_shift_enabler,
   output logic                     write_shift_enabler,
   output logic [1:0]               pc_operation,
   output logic [DATA_WIDTH-1:0]    proc_pc,
   output logic [INTRPT_WIDTH-1:0]  intrpt,
   output logic                     intrpt_ack,
   output logic                     pc_load,
   output logic [DATA_WIDTH-1:0]    pc_target,
   output logic                     stall,
   output logic                     user_mode
);

   typedef enum logic [2:0] {
      ST_KERNEL = 3'd0,
      ST_USER   = 3'd1,
      ST_SAVE   = 3'd2,
      ST_ENTER  = 3'd3,
      ST_EXIT   = 3'd4
   } state_t;

   state_t                   state, state_nxt;
   logic [QUANTUM_WIDTH-1:0] quantum_q;
   logic [QUANTUM_WIDTH-1:0] timer_q, timer_nxt;
   logic                     tmr_armed_q, tmr_armed_nxt;
   logic                     tmr_pend_q, tmr_pend_nxt;
   logic [INTRPT_WIDTH-1:0]  code_q, code_nxt;
   logic                     code_ext_q, code_ext_nxt;
   logic [DATA_WIDTH-1:0]    save_pc_q, save_pc_nxt;
   logic [DATA_WIDTH-1:0]    resume_pc_q, resume_pc_nxt;
   logic [QUANTUM_WIDTH-1:0] reload_val;

   logic                     shift_nxt, user_nxt, ack_nxt, load_nxt, stall_nxt;
   logic [1:0]               pc_op_nxt;
   logic [INTRPT_WIDTH-1:0]  intrpt_nxt;
   logic [DATA_WIDTH-1:0]    proc_pc_nxt, pc_target_nxt;

   logic                     ext_req, tmr_hit, tmr_req;

   // The timer hit is looked ahead by one count so the swap starts on the
   // very edge the count reaches zero; a hit that loses to an external
   // request is remembered in tmr_pend_q across the kernel visit.
   assign ext_req    = |ext_intrpt;
   assign tmr_hit    = tmr_armed_q && (timer_q == QUANTUM_WIDTH'(1));
   assign tmr_req    = tmr_pend_q || tmr_hit;
   assign reload_val = quantum_we ? quantum_data : quantum_q;

   // Next-state, timer, latches and Moore output decode of the next state.
   always_comb begin
      state_nxt     = state;
      timer_nxt     = timer_q;
      tmr_armed_nxt = tmr_armed_q;
      tmr_pend_nxt  = tmr_pend_q;
      code_nxt      = code_q;
      code_ext_nxt  = code_ext_q;
      save_pc_nxt   = save_pc_q;
      resume_pc_nxt = resume_pc_q;

      if (state == ST_USER && timer_q != '0) begin
         timer_nxt = timer_q - QUANTUM_WIDTH'(1);
      end
      if (state == ST_USER && tmr_hit) begin
         tmr_pend_nxt = 1'b1;
      end

      case (state)
         ST_KERNEL: begin
            if (rfe) begin
               state_nxt     = ST_EXIT;
               resume_pc_nxt = rfe_target;
            end
         end
         ST_USER: begin
            if (ext_req) begin
               state_nxt    = ST_SAVE;
               code_nxt     = ext_intrpt;
               code_ext_nxt = 1'b1;
               save_pc_nxt  = pc_in;
            end else if (tmr_req) begin
               state_nxt    = ST_SAVE;
               code_nxt     = TIMER_CODE;
               code_ext_nxt = 1'b0;
               save_pc_nxt  = pc_in;
               tmr_pend_nxt = 1'b0;
            end
         end
         ST_SAVE:  state_nxt = ST_ENTER;
         ST_ENTER: state_nxt = ST_KERNEL;
         ST_EXIT: begin
            state_nxt     = ST_USER;
            timer_nxt     = reload_val;
            tmr_armed_nxt = (reload_val != '0);
         end
         default:  state_nxt = ST_KERNEL;
      endcase

      shift_nxt     = 1'b0;
      user_nxt      = 1'b0;
      pc_op_nxt     = 2'b00;
      intrpt_nxt    = '0;
      ack_nxt       = 1'b0;
      load_nxt      = 1'b0;
      stall_nxt     = 1'b0;
      proc_pc_nxt   = proc_pc;
      pc_target_nxt = pc_target;

      case (state_nxt)
         ST_USER: begin
            shift_nxt = 1'b1;
            user_nxt  = 1'b1;
         end
         ST_SAVE: begin
            pc_op_nxt   = 2'b01;
            proc_pc_nxt = save_pc_nxt;
            stall_nxt   = 1'b1;
         end
         ST_ENTER: begin
            intrpt_nxt    = code_nxt;
            ack_nxt       = code_ext_nxt;
            load_nxt      = 1'b1;
            pc_target_nxt = KERNEL_VECTOR;
            stall_nxt     = 1'b1;
         end
         ST_EXIT: begin
            shift_nxt     = 1'b1;
            load_nxt      = 1'b1;
            pc_target_nxt = resume_pc_nxt;
            stall_nxt     = 1'b1;
         end
         default: ;
      endcase
   end

   // State, timer, latches and registered outputs; hlt freezes all but the
   // quantum register, which accepts writes in any state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state               <= ST_KERNEL;
         quantum_q           <= '0;
         timer_q             <= '0;
         tmr_armed_q         <= 1'b0;
         tmr_pend_q          <= 1'b0;
         code_q              <= '0;
         code_ext_q          <= 1'b0;
         save_pc_q           <= '0;
         resume_pc_q         <= '0;
         read_shift_enabler  <= 1'b0;
         write_shift_enabler <= 1'b0;
         pc_operation        <= 2'b00;
         proc_pc             <= '0;
         intrpt              <= '0;
         intrpt_ack          <= 1'b0;
         pc_load             <= 1'b0;
         pc_target           <= '0;
         stall               <= 1'b0;
         user_mode           <= 1'b0;
      end else begin
         if (quantum_we) begin
            quantum_q <= quantum_data;
         end
         if (!hlt) begin
            state               <= state_nxt;
            timer_q             <= timer_nxt;
            tmr_armed_q         <= tmr_armed_nxt;
            tmr_pend_q          <= tmr_pend_nxt;
            code_q              <= code_nxt;
            code_ext_q          <= code_ext_nxt;
            save_pc_q           <= save_pc_nxt;
            resume_pc_q         <= resume_pc_nxt;
            read_shift_enabler  <= shift_nxt;
            write_shift_enabler <= shift_nxt;
            pc_operation        <= pc_op_nxt;
            proc_pc             <= proc_pc_nxt;
            intrpt              <= intrpt_nxt;
            intrpt_ack          <= ack_nxt;
            pc_load             <= load_nxt;
            pc_target           <= pc_target_nxt;
            stall               <= stall_nxt;
            user_mode           <= user_nxt;
         end
      end
   end

endmodule

// File: tb/tb_context_swap_controller.sv
// Bench for context_swap_controller: directed vector table, hand-written
// corner sequences, then random traffic against a queue-based reference.
module tb_context_swap_controller;

   localparam logic [5:0]  TC = 6'd1;
   localparam logic [31:0] KV = 32'd0;

   typedef struct packed {
      logic        rse;
      logic        wse;
      logic        um;
      logic [1:0]  op;
      logic [31:0] ppc;
      logic [5:0]  ic;
      logic        ak;
      logic        pl;
      logic [31:0] pt;
      logic        st;
   } out_t;

   typedef struct packed {
      logic        hlt;
      logic [5:0]  ext;
      logic        rfe;
      logic [31:0] tgt;
      logic [31:0] pc;
      logic        qwe;
      logic [15:0] qd;
   } in_t;

   typedef struct {
      string name;
      in_t   in;
      out_t  exp;
   } row_t;

   typedef struct packed {
      out_t o;
      logic reload;
   } rec_t;

   logic        clk, reset, hlt, rfe, quantum_we;
   logic [5:0]  ext_intrpt;
   logic [31:0] rfe_target, pc_in;
   logic [15:0] quantum_data;
   logic        read_shift_enabler, write_shift_enabler, intrpt_ack;
   logic        pc_load, stall, user_mode;
   logic [1:0]  pc_operation;
   logic [31:0] proc_pc, pc_target;
   logic [5:0]  intrpt;

   int n_checks = 0;
   int n_errors = 0;

   context_swap_controller dut (
      .clk                 (clk),
      .reset               (reset),
      .hlt                 (hlt),
      .ext_intrpt          (ext_intrpt),
      .rfe                 (rfe),
      .rfe_target          (rfe_target),
      .pc_in               (pc_in),
      .quantum_we          (quantum_we),
      .quantum_data        (quantum_data),
      .read_shift_enabler  (read_shift_enabler),
      .write_shift_enabler (write_shift_enabler),
      .pc_operation        (pc_operation),
      .proc_pc             (proc_pc),
      .intrpt              (intrpt),
      .intrpt_ack          (intrpt_ack),
      .pc_load             (pc_load),
      .pc_target           (pc_target),
      .stall               (stall),
      .user_mode           (user_mode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic out_t mk(logic sh, logic um, logic [1:0] op, logic [31:0] ppc,
                               logic [5:0] ic, logic ak, logic pl, logic [31:0] pt, logic st);
      out_t r;
      r.rse = sh; r.wse = sh; r.um = um; r.op = op; r.ppc = ppc;
      r.ic = ic; r.ak = ak; r.pl = pl; r.pt = pt; r.st = st;
      return r;
   endfunction

   function automatic out_t k_o(logic [31:0] ppc, logic [31:0] pt);
      return mk(1'b0, 1'b0, 2'b00, ppc, 6'd0, 1'b0, 1'b0, pt, 1'b0);
   endfunction
   function automatic out_t u_o(logic [31:0] ppc, logic [31:0] pt);
      return mk(1'b1, 1'b1, 2'b00, ppc, 6'd0, 1'b0, 1'b0, pt, 1'b0);
   endfunction
   function automatic out_t ex_o(logic [31:0] ppc, logic [31:0] pt);
      return mk(1'b1, 1'b0, 2'b00, ppc, 6'd0, 1'b0, 1'b1, pt, 1'b1);
   endfunction
   function automatic out_t sv_o(logic [31:0] ppc, logic [31:0] pt);
      return mk(1'b0, 1'b0, 2'b01, ppc, 6'd0, 1'b0, 1'b0, pt, 1'b1);
   endfunction
   function automatic out_t en_o(logic [31:0] ppc, logic [5:0] ic, logic ak);
      return mk(1'b0, 1'b0, 2'b00, ppc, ic, ak, 1'b1, KV, 1'b1);
   endfunction

   function automatic in_t mi(logic h, logic [5:0] e, logic r, logic [31:0] t,
                              logic [31:0] p, logic w, logic [15:0] q);
      in_t v;
      v.hlt = h; v.ext = e; v.rfe = r; v.tgt = t; v.pc = p; v.qwe = w; v.qd = q;
      return v;
   endfunction

   function automatic out_t act();
      return out_t'({read_shift_enabler, write_shift_enabler, user_mode, pc_operation,
                     proc_pc, intrpt, intrpt_ack, pc_load, pc_target, stall});
   endfunction

   task automatic check(input string name, input out_t exp);
      out_t a;
      a = act();
      n_checks++;
      if (a !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, a, exp);
      end
   endtask

   task automatic apply(input in_t v);
      hlt = v.hlt; ext_intrpt = v.ext; rfe = v.rfe; rfe_target = v.tgt;
      pc_in = v.pc; quantum_we = v.qwe; quantum_data = v.qd;
   endtask

   // Reference: a swap is a scripted sequence of output records played one
   // per unfrozen edge; the quantum is tracked as a count of USER cycles.
   out_t  m_out;
   rec_t  mq[$];
   logic  m_user, m_owed;
   int    m_quantum, m_loaded, m_ucyc;

   task automatic m_reset();
      m_out = '0; mq.delete(); m_user = 1'b0; m_owed = 1'b0;
      m_quantum = 0; m_loaded = 0; m_ucyc = 0;
   endtask

   task automatic m_enter(input logic [5:0] code, input logic ak);
      rec_t r;
      m_out = sv_o(pc_in, m_out.pt);
      r.reload = 1'b0;
      r.o = en_o(pc_in, code, ak);       mq.push_back(r);
      r.o = k_o(pc_in, KV);              mq.push_back(r);
      m_user = 1'b0;
   endtask

   task automatic m_step();
      rec_t r;
      logic expire;
      if (reset) begin
         m_reset();
         return;
      end
      if (!hlt) begin
         if (mq.size() != 0) begin
            r = mq.pop_front();
            if (r.reload) begin
               m_loaded = quantum_we ? int'(quantum_data) : m_quantum;
               m_ucyc   = 0;
            end
            m_out = r.o;
         end else if (!m_user) begin
            if (rfe) begin
               m_out    = ex_o(m_out.ppc, rfe_target);
               r.o      = u_o(m_out.ppc, rfe_target);
               r.reload = 1'b1;
               mq.push_back(r);
               m_user   = 1'b1;
            end
         end else begin
            expire = (m_loaded != 0) && (m_ucyc + 1 == m_loaded);
            if (ext_intrpt != 6'd0) begin
               if (expire) m_owed = 1'b1;
               m_enter(ext_intrpt, 1'b1);
            end else if (expire || m_owed) begin
               m_owed = 1'b0;
               m_enter(TC, 1'b0);
            end else begin
               m_ucyc++;
            end
         end
      end
      if (quantum_we) m_quantum = int'(quantum_data);
   endtask

   task automatic tick();
      m_step();
      @(posedge clk);
      #1;
   endtask

   row_t rows[$];

   task automatic add(input string n, input in_t v, input out_t e);
      row_t r;
      r.name = n; r.in = v; r.exp = e;
      rows.push_back(r);
   endtask

   initial begin
      in_t idle;
      idle = mi(1'b0, 6'd0, 1'b0, 32'h0, 32'h0, 1'b0, 16'd0);
      m_reset();
      reset = 1'b1;
      apply(idle);
      #1;
      check("reset_values", '0);
      tick();
      tick();
      check("reset_held", '0);
      reset = 1'b0;

      add("q_write",        mi(0, 0, 0, 0, 0, 1, 5),        k_o(0, 0));
      add("rfe_exit",       mi(0, 0, 1, 32'h40, 0, 0, 0),   ex_o(0, 32'h40));
      add("user_entry",     mi(0, 0, 0, 0, 32'h44, 0, 0),   u_o(0, 32'h40));
      add("ext_save",       mi(0, 3, 0, 0, 32'h44, 0, 0),   sv_o(32'h44, 32'h40));
      add("ext_enter",      mi(0, 3, 0, 0, 32'h44, 0, 0),   en_o(32'h44, 3, 1));
      add("ext_kernel",     idle,                           k_o(32'h44, 0));
      add("q5_exit",        mi(0, 0, 1, 32'h80, 0, 0, 0),   ex_o(32'h44, 32'h80));
      for (int i = 0; i < 5; i++) add("q5_user", idle,     u_o(32'h44, 32'h80));
      add("q5_save",        mi(0, 0, 0, 0, 32'h90, 0, 0),   sv_o(32'h90, 32'h80));
      add("q5_enter",       idle,                           en_o(32'h90, TC, 0));
      add("q5_kernel",      idle,                           k_o(32'h90, 0));
      add("sim_exit",       mi(0, 0, 1, 32'hA0, 0, 0, 0),   ex_o(32'h90, 32'hA0));
      for (int i = 0; i < 5; i++) add("sim_user", idle,    u_o(32'h90, 32'hA0));
      add("sim_ext_save",   mi(0, 7, 0, 0, 32'hB0, 0, 0),   sv_o(32'hB0, 32'hA0));
      add("sim_ext_enter",  mi(0, 7, 0, 0, 0, 0, 0),        en_o(32'hB0, 7, 1));
      add("sim_kernel",     idle,                           k_o(32'hB0, 0));
      add("sim_rfe",        mi(0, 0, 1, 32'hC0, 0, 0, 0),   ex_o(32'hB0, 32'hC0));
      add("sim_user1",      idle,                           u_o(32'hB0, 32'hC0));
      add("sim_tmr_save",   mi(0, 0, 0, 0, 32'hC4, 0, 0),   sv_o(32'hC4, 32'hC0));
      add("sim_tmr_enter",  idle,                           en_o(32'hC4, TC, 0));
      add("sim_tmr_kernel", idle,                           k_o(32'hC4, 0));
      add("kext_ignored",   mi(0, 2, 0, 0, 0, 0, 0),        k_o(32'hC4, 0));
      add("kext_ignored",   mi(0, 2, 0, 0, 0, 0, 0),        k_o(32'hC4, 0));
      add("kext_rfe",       mi(0, 2, 1, 32'hD0, 0, 0, 0),   ex_o(32'hC4, 32'hD0));
      add("kext_user1",     mi(0, 2, 0, 0, 0, 0, 0),        u_o(32'hC4, 32'hD0));
      add("kext_save",      mi(0, 2, 0, 0, 32'hD4, 0, 0),   sv_o(32'hD4, 32'hD0));
      add("kext_enter",     mi(0, 2, 0, 0, 0, 0, 0),        en_o(32'hD4, 2, 1));
      add("kext_kernel",    idle,                           k_o(32'hD4, 0));

      foreach (rows[i]) begin
         apply(rows[i].in);
         tick();
         check(rows[i].name, rows[i].exp);
      end

      // hlt in USER freezes timer and outputs; rfe during hlt is lost
      apply(mi(0, 0, 0, 0, 0, 1, 3));     tick(); check("h_qwrite", k_o(32'hD4, 0));
      apply(mi(0, 0, 1, 32'h100, 0, 0, 0)); tick(); check("h_exit", ex_o(32'hD4, 32'h100));
      apply(idle);                        tick(); check("h_user0", u_o(32'hD4, 32'h100));
      tick();                             check("h_user1", u_o(32'hD4, 32'h100));
      apply(mi(1, 4, 1, 32'h1F0, 0, 1, 9));
      for (int i = 0; i < 4; i++) begin
         tick();
         check("hlt_frozen", u_o(32'hD4, 32'h100));
      end
      apply(mi(0, 0, 0, 0, 0, 1, 3));     tick(); check("h_user2", u_o(32'hD4, 32'h100));
      apply(mi(0, 0, 0, 0, 32'h104, 0, 0)); tick(); check("h_save", sv_o(32'h104, 32'h100));
      apply(idle);                        tick(); check("h_enter", en_o(32'h104, TC, 0));
      tick();                             check("h_kernel", k_o(32'h104, 0));
      apply(mi(1, 0, 1, 32'h200, 0, 0, 0)); tick(); check("h_rfe_hlt", k_o(32'h104, 0));
      apply(idle);                        tick(); check("rfe_lost", k_o(32'h104, 0));

      // quantum write while in EXIT is the value loaded
      apply(mi(0, 0, 1, 32'h300, 0, 0, 0)); tick(); check("qx_exit", ex_o(32'h104, 32'h300));
      apply(mi(0, 0, 0, 0, 0, 1, 2));     tick(); check("qx_user0", u_o(32'h104, 32'h300));
      apply(idle);                        tick(); check("qx_user1", u_o(32'h104, 32'h300));
      apply(mi(0, 0, 0, 0, 32'h308, 0, 0)); tick(); check("qx_save", sv_o(32'h308, 32'h300));
      apply(idle);                        tick(); check("qx_enter", en_o(32'h308, TC, 0));
      tick();                             check("qx_kernel", k_o(32'h308, 0));

      // reset in the middle of ENTER, then quantum 0 never expires
      apply(mi(0, 0, 1, 32'h400, 0, 0, 0)); tick(); check("r_exit", ex_o(32'h308, 32'h400));
      apply(idle);                        tick(); check("r_user", u_o(32'h308, 32'h400));
      apply(mi(0, 5, 0, 0, 32'h404, 0, 0)); tick(); check("r_save", sv_o(32'h404, 32'h400));
      tick();                             check("r_enter", en_o(32'h404, 5, 1));
      #2 reset = 1'b1;
      #1 check("reset_async", '0);
      apply(idle);
      tick();                             check("reset_clocked", '0);
      reset = 1'b0;
      tick();                             check("after_reset", '0);
      apply(mi(0, 0, 1, 32'h500, 0, 0, 0)); tick(); check("q0_exit", ex_o(0, 32'h500));
      apply(idle);
      for (int i = 0; i < 12; i++) begin
         tick();
         check("q0_no_expiry", u_o(0, 32'h500));
      end
      apply(mi(0, 1, 0, 0, 32'h504, 0, 0)); tick(); check("q0_save", sv_o(32'h504, 32'h500));
      tick();                             check("q0_enter", en_o(32'h504, 1, 1));
      apply(idle);                        tick(); check("q0_kernel", k_o(32'h504, 0));

      // random traffic against the reference
      ext_intrpt = 6'd0;
      for (int c = 0; c < 3000; c++) begin
         reset        = ($urandom_range(0, 199) == 0);
         hlt          = ($urandom_range(0, 9) == 0);
         rfe          = ($urandom_range(0, 5) == 0);
         rfe_target   = $urandom;
         pc_in        = $urandom;
         quantum_we   = ($urandom_range(0, 15) == 0);
         quantum_data = 16'($urandom_range(0, 7));
         if (ext_intrpt == 6'd0 && $urandom_range(0, 19) == 0)
            ext_intrpt = 6'($urandom_range(1, 63));
         tick();
         check("random", m_out);
         if (intrpt_ack || reset) ext_intrpt = 6'd0;
      end
      reset = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
